// File: rtl/gate_pkg.sv
// Shared op codes, limits and the per-bit reduction used by gate_pipe.
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  localparam logic [2:0] OP_RESERVED_MIN = 3'd6;

  // Upper bound on operand count handled by gate_reduce.
  localparam int MAX_N = 16;

  // Reduces one bit column of operands. bits[i] is bit b of operand i; only
  // the first num_in entries take part. Inverting ops invert the final
  // reduction, and reserved codes always give 0.
  function automatic logic gate_reduce(input logic [2:0] op,
                                       input logic [MAX_N-1:0] bits,
                                       input int num_in);
    logic acc;
    acc = bits[0];
    for (int i = 1; i < MAX_N; i++) begin
      if (i < num_in) begin
        case (op)
          OP_AND, OP_NAND: acc = acc & bits[i];
          OP_OR,  OP_NOR:  acc = acc | bits[i];
          OP_XOR, OP_XNOR: acc = acc ^ bits[i];
          default:         acc = 1'b0;
        endcase
      end
    end
    if (op >= OP_RESERVED_MIN) begin
      acc = 1'b0;
    end else if (op == OP_NAND || op == OP_NOR || op == OP_XNOR) begin
      acc = ~acc;
    end
    return acc;
  endfunction

endpackage

// File: rtl/gate_if.sv
// Bundle of all gate_pipe data/handshake signals (clock and reset excluded).
interface gate_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*WIDTH-1:0]   in_data;
  logic [2:0]                in_op;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_err;
  logic [15:0]               count;
endinterface

// File: rtl/gate_fifo.sv
// Pointer-based FIFO; full/empty come from an occupancy counter.
// Head reads as zero while empty so nothing stale is ever presented.
module gate_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (occ_q == CNT_W'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  // Next pointers and occupancy; simultaneous push/pop leaves occupancy alone.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (do_push) wr_d = next_ptr(wr_q);
    if (do_pop)  rd_d = next_ptr(rd_q);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Pointer/occupancy registers; reset discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: entries are only visible while occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/gate_pipe.sv
// N-operand bitwise logic stage with valid/ready on both sides, an output
// FIFO and a delivered-result counter.
module gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic [15:0]             count
);
  logic [WIDTH-1:0] result;
  logic             res_err;
  logic             push, pop;
  logic             full, empty;
  logic [WIDTH:0]   head;
  logic [15:0]      count_q, count_d;

  // Reduce each bit column across all operands.
  always_comb begin
    logic [MAX_N-1:0] col;
    col    = '0;
    result = '0;
    for (int b = 0; b < WIDTH; b++) begin
      col = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        col[i] = in_data[i*WIDTH + b];
      end
      result[b] = gate_reduce(in_op, col, NUM_IN);
    end
  end

  assign res_err = (in_op >= OP_RESERVED_MIN);

  // in_ready depends only on FIFO state, never on out_ready.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;
  assign out_data  = head[WIDTH-1:0];
  assign out_err   = head[WIDTH];
  assign count     = count_q;

  gate_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({res_err, result}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Delivered-result count, wraps naturally at 16 bits.
  always_comb begin
    count_d = count_q;
    if (pop) count_d = count_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: tb/tb_gate_pipe.sv
module tb_gate_pipe;
  import gate_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gate_if #(.WIDTH(8), .NUM_IN(2)) vif ();
  gate_if #(.WIDTH(8), .NUM_IN(3)) vif3 ();

  gate_pipe #(.WIDTH(8), .NUM_IN(2), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(vif.in_valid), .in_ready(vif.in_ready), .in_data(vif.in_data),
    .in_op(vif.in_op), .out_valid(vif.out_valid), .out_ready(vif.out_ready),
    .out_data(vif.out_data), .out_err(vif.out_err), .count(vif.count)
  );

  gate_pipe #(.WIDTH(8), .NUM_IN(3), .DEPTH(2)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(vif3.in_valid), .in_ready(vif3.in_ready), .in_data(vif3.in_data),
    .in_op(vif3.in_op), .out_valid(vif3.out_valid), .out_ready(vif3.out_ready),
    .out_data(vif3.out_data), .out_err(vif3.out_err), .count(vif3.count)
  );

  always #5 clk = ~clk;

  logic [8:0] q2[$];
  logic [8:0] q3[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitors: compare each delivered result with the queue head.
  always @(negedge clk) begin
    if (!rst && vif.out_valid && vif.out_ready) begin
      logic [8:0] e;
      if (q2.size() == 0) begin
        n_total++;
        $display("FAIL mon2: unexpected result %h err %b", vif.out_data, vif.out_err);
      end else begin
        e = q2.pop_front();
        check("mon2", {23'd0, vif.out_err, vif.out_data}, {23'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vif3.out_valid && vif3.out_ready) begin
      logic [8:0] e;
      if (q3.size() == 0) begin
        n_total++;
        $display("FAIL mon3: unexpected result %h err %b", vif3.out_data, vif3.out_err);
      end else begin
        e = q3.pop_front();
        check("mon3", {23'd0, vif3.out_err, vif3.out_data}, {23'd0, e});
      end
    end
  end

  // Called 1 time unit after a rising edge; returns 1 unit after the accept edge.
  task automatic send2(input logic [2:0] op, input logic [15:0] d, input logic [8:0] exp);
    int guard = 0;
    vif.in_valid = 1'b1;
    vif.in_op    = op;
    vif.in_data  = d;
    while (!vif.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_total++;
      $display("FAIL send2_timeout: in_ready stuck at %b, required 1", vif.in_ready);
      vif.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q2.push_back(exp);
    #1;
    vif.in_valid = 1'b0;
  endtask

  task automatic send3(input logic [2:0] op, input logic [23:0] d, input logic [8:0] exp);
    int guard = 0;
    vif3.in_valid = 1'b1;
    vif3.in_op    = op;
    vif3.in_data  = d;
    while (!vif3.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_total++;
      $display("FAIL send3_timeout: in_ready stuck at %b, required 1", vif3.in_ready);
      vif3.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q3.push_back(exp);
    #1;
    vif3.in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vif.in_valid  = 1'b0; vif.in_data  = '0; vif.in_op  = '0; vif.out_ready  = 1'b0;
    vif3.in_valid = 1'b0; vif3.in_data = '0; vif3.in_op = '0; vif3.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, vif.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, vif.out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, vif.out_data},  32'd0);
    check("rst_out_err",   {31'd0, vif.out_err},   32'd0);
    check("rst_count",     {16'd0, vif.count},     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two operands F0/0F, all six ops back-to-back.
    vif.out_ready = 1'b1;
    send2(OP_AND,  16'h0FF0, 9'h000);
    send2(OP_OR,   16'h0FF0, 9'h0FF);
    send2(OP_XOR,  16'h0FF0, 9'h0FF);
    send2(OP_NAND, 16'h0FF0, 9'h0FF);
    send2(OP_NOR,  16'h0FF0, 9'h000);
    send2(OP_XNOR, 16'h0FF0, 9'h000);
    @(posedge clk); #1;
    check("six_ops_count",     {16'd0, vif.count},     32'd6);
    check("six_ops_drained",   {31'd0, vif.out_valid}, 32'd0);

    // Three operands AA/CC/F0.
    vif3.out_ready = 1'b1;
    send3(OP_XOR,  24'hF0CCAA, 9'h096);
    send3(OP_XNOR, 24'hF0CCAA, 9'h069);
    send3(OP_NAND, 24'hF0CCAA, 9'h07F);
    send3(OP_AND,  24'hF0CCAA, 9'h080);
    send3(OP_OR,   24'hF0CCAA, 9'h0FE);
    send3(OP_NOR,  24'hF0CCAA, 9'h001);
    @(posedge clk); #1;
    check("n3_count", {16'd0, vif3.count}, 32'd6);

    // Backpressure: fill, hold a third set, then drain.
    vif.out_ready = 1'b0;
    send2(OP_OR,  16'h0F30, 9'h03F);
    send2(OP_XOR, 16'h0FFF, 9'h0F0);
    check("full_in_ready",  {31'd0, vif.in_ready},  32'd0);
    check("full_out_valid", {31'd0, vif.out_valid}, 32'd1);
    vif.in_valid = 1'b1;
    vif.in_op    = OP_AND;
    vif.in_data  = 16'hFF3C;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("held_in_ready", {31'd0, vif.in_ready}, 32'd0);
      check("held_head",     {24'd0, vif.out_data}, 32'h3F);
    end
    vif.out_ready = 1'b1;
    @(posedge clk); #1;
    check("ready_after_pop", {31'd0, vif.in_ready}, 32'd1);
    @(posedge clk);
    q2.push_back(9'h03C);
    #1;
    vif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", {31'd0, vif.out_valid}, 32'd0);

    // Reserved op flags an error; the following op does not.
    send2(3'd7,   16'h0FF0, 9'h100);
    send2(OP_OR,  16'h0FF0, 9'h0FF);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset with two entries buffered.
    vif.out_ready = 1'b0;
    send2(OP_OR,  16'h1122, 9'h133 & 9'h0FF);
    send2(OP_AND, 16'h1122, 9'h000);
    check("pre_rst_valid", {31'd0, vif.out_valid}, 32'd1);
    check("pre_rst_count_nz", {31'd0, (vif.count != 16'd0)}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_in_ready",  {31'd0, vif.in_ready},  32'd1);
    check("arst_out_valid", {31'd0, vif.out_valid}, 32'd0);
    check("arst_out_data",  {24'd0, vif.out_data},  32'd0);
    check("arst_out_err",   {31'd0, vif.out_err},   32'd0);
    check("arst_count",     {16'd0, vif.count},     32'd0);
    q2.delete();
    @(negedge clk);
    rst = 1'b0;
    vif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_stale", {31'd0, vif.out_valid}, 32'd0);
    check("post_rst_count",    {16'd0, vif.count},     32'd0);

    // Counter wrap: 65535 deliveries, then one more.
    for (int i = 0; i < 65535; i++) begin
      send2(OP_OR, 16'h00FF, 9'h0FF);
    end
    @(posedge clk); #1;
    check("count_ffff", {16'd0, vif.count}, 32'h0000FFFF);
    send2(OP_XOR, 16'h00FF, 9'h0FF);
    @(posedge clk); #1;
    check("count_wrap", {16'd0, vif.count}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("q2_empty", q2.size(), 32'd0);
    check("q3_empty", q3.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
